// File: rtl/bft_leaf_endpoint_if.sv
// Signals between a BFT leaf endpoint and its surroundings.
// Carries the BFT packet ports and the user TX/RX word streams.
interface bft_leaf_endpoint_if #(
   parameter int PACKET_BITS  = 49,
   parameter int PAYLOAD_BITS = 32,
   parameter int CREDIT_BITS  = 8
);
   logic [PACKET_BITS-1:0]  din_leaf_bft2endpoint;
   logic [PACKET_BITS-1:0]  dout_leaf_endpoint2bft;
   logic                    resend;
   logic                    resend_out;
   logic [PAYLOAD_BITS-1:0] s_data;
   logic                    s_vld;
   logic                    s_ack;
   logic [PAYLOAD_BITS-1:0] m_data;
   logic                    m_vld;
   logic                    m_ack;
   logic [CREDIT_BITS-1:0]  credits;

   modport slave (
      input  din_leaf_bft2endpoint, resend, s_data, s_vld, m_ack,
      output dout_leaf_endpoint2bft, resend_out, s_ack, m_data, m_vld, credits
   );

   modport master (
      output din_leaf_bft2endpoint, resend, s_data, s_vld, m_ack,
      input  dout_leaf_endpoint2bft, resend_out, s_ack, m_data, m_vld, credits
   );
endinterface

// File: rtl/bft_leaf_endpoint.sv
// BFT-side peer of a leaf: packs a credit-gated user stream into BFT packets and
// unpacks inbound packets into a FWFT FIFO, returning freespace updates to the sender.
module bft_leaf_endpoint #(
   parameter int PACKET_BITS           = 49,
   parameter int PAYLOAD_BITS          = 32,
   parameter int NUM_LEAF_BITS         = 5,
   parameter int NUM_PORT_BITS         = 4,
   parameter int NUM_ADDR_BITS         = 7,
   parameter int DST_LEAF              = 2,
   parameter int DST_PORT              = 2,
   parameter int SELF_LEAF             = 1,
   parameter int CREDIT_INIT           = 128,
   parameter int RX_DEPTH              = 16,
   parameter int FREESPACE_UPDATE_SIZE = 8
) (
   input logic                clk,
   input logic                reset,
   bft_leaf_endpoint_if.slave bus
);
   // state | meaning
   // SEND  | drive a pending update, else an accepted user word, else an idle packet
   // HOLD  | BFT rejected the driven packet; keep re-presenting it until accepted

   localparam int CREDIT_BITS = 8;
   localparam int PTR_BITS    = $clog2(RX_DEPTH);
   localparam int CNT_BITS    = PTR_BITS + 1;
   localparam int POP_BITS    = $clog2(FREESPACE_UPDATE_SIZE + 1);
   localparam int SNAP_BITS   = PAYLOAD_BITS - NUM_LEAF_BITS;
   localparam int PORT_LSB    = PAYLOAD_BITS + NUM_ADDR_BITS;

   typedef enum logic {SEND, HOLD} tx_state_t;

   tx_state_t                state;
   logic [PACKET_BITS-1:0]   dout;
   logic [NUM_ADDR_BITS-1:0] tx_seq;
   logic [CREDIT_BITS-1:0]   credits;
   logic                     upd_pending;
   logic [SNAP_BITS-1:0]     upd_snap;
   logic [POP_BITS-1:0]      pop_cnt;

   logic                     in_valid;
   logic [NUM_PORT_BITS-1:0] in_port;
   logic [PAYLOAD_BITS-1:0]  in_payload;
   logic                     unused_fields;

   assign in_valid      = bus.din_leaf_bft2endpoint[PACKET_BITS-1];
   assign in_port       = bus.din_leaf_bft2endpoint[PORT_LSB +: NUM_PORT_BITS];
   assign in_payload    = bus.din_leaf_bft2endpoint[PAYLOAD_BITS-1:0];
   // Leaf and sequence fields of inbound packets carry nothing this endpoint acts on.
   assign unused_fields = ^{bus.din_leaf_bft2endpoint[PACKET_BITS-2 -: NUM_LEAF_BITS],
                            bus.din_leaf_bft2endpoint[PAYLOAD_BITS +: NUM_ADDR_BITS]};

   logic s_ack;
   logic xfer;
   logic hold_req;
   logic ctrl_send;

   assign s_ack     = !reset && (state == SEND) && (credits != '0) && !bus.resend && !upd_pending;
   assign xfer      = bus.s_vld && s_ack;
   assign hold_req  = bus.resend && dout[PACKET_BITS-1];
   assign ctrl_send = (state == SEND) && !hold_req && upd_pending;

   logic [CREDIT_BITS-1:0] credit_ret;
   logic [CREDIT_BITS+1:0] credit_sum;
   logic [CREDIT_BITS+1:0] credit_next;

   always_comb begin
      credit_ret = '0;
      if (in_valid && (in_port == '0))
         credit_ret = in_payload[7:0];
      credit_sum  = {2'b00, credits} + {2'b00, credit_ret} - {{(CREDIT_BITS+1){1'b0}}, xfer};
      credit_next = credit_sum;
      if (credit_sum > (CREDIT_BITS+2)'(CREDIT_INIT))
         credit_next = (CREDIT_BITS+2)'(CREDIT_INIT);
   end

   logic [PAYLOAD_BITS-1:0] mem [RX_DEPTH];
   logic [PTR_BITS-1:0]     wr_ptr;
   logic [PTR_BITS-1:0]     rd_ptr;
   logic [CNT_BITS-1:0]     count;
   logic                    resend_out;
   logic                    m_vld;
   logic                    push_req;
   logic                    full;
   logic                    pop;
   logic                    push_ok;

   assign m_vld    = (count != '0);
   assign full     = (count == CNT_BITS'(RX_DEPTH));
   assign pop      = m_vld && bus.m_ack;
   assign push_req = in_valid && (in_port != '0);
   assign push_ok  = push_req && (!full || pop);

   logic [POP_BITS-1:0] pop_sum;
   logic                crossing;

   assign pop_sum  = pop_cnt + POP_BITS'(pop);
   assign crossing = (pop_sum == POP_BITS'(FREESPACE_UPDATE_SIZE));

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SEND;
         dout        <= '0;
         tx_seq      <= '0;
         credits     <= CREDIT_BITS'(CREDIT_INIT);
         upd_pending <= 1'b0;
         upd_snap    <= '0;
         pop_cnt     <= '0;
      end else begin
         credits <= CREDIT_BITS'(credit_next);
         case (state)
            SEND: begin
               if (hold_req) begin
                  state <= HOLD;
               end else if (upd_pending) begin
                  dout <= {1'b1, NUM_LEAF_BITS'(DST_LEAF), {NUM_PORT_BITS{1'b0}}, tx_seq,
                           NUM_LEAF_BITS'(SELF_LEAF), upd_snap};
               end else if (xfer) begin
                  dout   <= {1'b1, NUM_LEAF_BITS'(DST_LEAF), NUM_PORT_BITS'(DST_PORT), tx_seq,
                             bus.s_data};
                  tx_seq <= tx_seq + 1'b1;
               end else begin
                  dout <= '0;
               end
            end
            HOLD: begin
               if (!bus.resend) begin
                  state <= SEND;
                  dout  <= '0;
               end
            end
         endcase
         // A crossing while an unsent update is pending folds into the same snapshot.
         if (crossing) begin
            upd_pending <= 1'b1;
            upd_snap    <= ((upd_pending && !ctrl_send) ? upd_snap : '0) +
                           SNAP_BITS'(FREESPACE_UPDATE_SIZE);
            pop_cnt     <= pop_sum - POP_BITS'(FREESPACE_UPDATE_SIZE);
         end else begin
            pop_cnt <= pop_sum;
            if (ctrl_send)
               upd_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= in_payload;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         resend_out <= 1'b0;
      end else begin
         resend_out <= push_req && full && !pop;
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.dout_leaf_endpoint2bft = dout;
   assign bus.resend_out             = resend_out;
   assign bus.s_ack                  = s_ack;
   assign bus.m_vld                  = m_vld;
   assign bus.m_data                 = m_vld ? mem[rd_ptr] : '0;
   assign bus.credits                = credits;
endmodule

// File: tb/tb_bft_leaf_endpoint.sv
// Bench for bft_leaf_endpoint: directed scenarios with random payloads plus a
// randomized RX run checked against a queue model of the FIFO and update packets.
module tb_bft_leaf_endpoint;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_seq;
   int   exp_credits;

   bft_leaf_endpoint_if bus ();

   bft_leaf_endpoint dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   wire [48:0] dout       = bus.dout_leaf_endpoint2bft;
   wire        s_ack      = bus.s_ack;
   wire        m_vld      = bus.m_vld;
   wire [31:0] m_data     = bus.m_data;
   wire        resend_out = bus.resend_out;
   wire [7:0]  credits    = bus.credits;

   function automatic logic [48:0] pkt(input int leaf, input int port, input int addr,
                                       input logic [31:0] payload);
      return {1'b1, leaf[4:0], port[3:0], addr[6:0], payload};
   endfunction

   function automatic logic [48:0] ctrl_pkt(input int seq, input int count);
      logic [31:0] p;
      p = {5'd1, 27'(count)};
      return pkt(2, 0, seq, p);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.din_leaf_bft2endpoint = '0;
      bus.resend = 1'b0;
      bus.s_vld  = 1'b0;
      bus.s_data = '0;
      bus.m_ack  = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_seq = 0;
      exp_credits = 128;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      n_checks++; if (dout !== 49'd0) begin n_fail++; $display("FAIL reset dout: got %h want 0", dout); end
      n_checks++; if (resend_out !== 1'b0) begin n_fail++; $display("FAIL reset resend_out: got %b want 0", resend_out); end
      n_checks++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL reset s_ack: got %b want 0", s_ack); end
      n_checks++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL reset m_vld: got %b want 0", m_vld); end
      n_checks++; if (m_data !== 32'd0) begin n_fail++; $display("FAIL reset m_data: got %h want 0", m_data); end
      n_checks++; if (credits !== 8'd128) begin n_fail++; $display("FAIL reset credits: got %0d want 128", credits); end
      reset = 1'b0;
      #1;
      n_checks++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL post_reset s_ack: got %b want 1", s_ack); end
      exp_seq = 0;
      exp_credits = 128;
   endtask

   task automatic test_tx_basic;
      for (int i = 0; i < 5; i++) begin
         bus.s_vld  = 1'b1;
         bus.s_data = 32'hA0 + 32'(i);
         #1;
         n_checks++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL tx_basic s_ack%0d: got %b want 1", i, s_ack); end
         tick();
         n_checks++; if (dout !== pkt(2, 2, exp_seq, 32'hA0 + 32'(i))) begin n_fail++; $display("FAIL tx_basic pkt%0d: got %h want %h", i, dout, pkt(2, 2, exp_seq, 32'hA0 + 32'(i))); end
         exp_seq++;
         exp_credits--;
      end
      bus.s_vld = 1'b0;
      tick();
      n_checks++; if (dout !== 49'd0) begin n_fail++; $display("FAIL tx_basic idle dout: got %h want 0", dout); end
      n_checks++; if (credits !== 8'(exp_credits)) begin n_fail++; $display("FAIL tx_basic credits: got %0d want %0d", credits, exp_credits); end
   endtask

   task automatic test_credit_return;
      int n;
      logic [31:0] d;
      n = exp_credits;
      for (int i = 0; i < n; i++) begin
         d = $urandom;
         bus.s_vld  = 1'b1;
         bus.s_data = d;
         #1;
         n_checks++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL drain s_ack%0d: got %b want 1", i, s_ack); end
         tick();
         n_checks++; if (dout !== pkt(2, 2, exp_seq, d)) begin n_fail++; $display("FAIL drain pkt%0d: got %h want %h", i, dout, pkt(2, 2, exp_seq, d)); end
         exp_seq++;
         exp_credits--;
      end
      #1;
      n_checks++; if (credits !== 8'd0) begin n_fail++; $display("FAIL empty credits: got %0d want 0", credits); end
      n_checks++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL empty s_ack: got %b want 0", s_ack); end
      tick();
      n_checks++; if (dout !== 49'd0) begin n_fail++; $display("FAIL empty dout: got %h want 0", dout); end
      bus.s_vld = 1'b0;
      bus.din_leaf_bft2endpoint = pkt(2, 0, 0, 32'd8);
      tick();
      bus.din_leaf_bft2endpoint = '0;
      n_checks++; if (credits !== 8'd8) begin n_fail++; $display("FAIL return8 credits: got %0d want 8", credits); end
      d = $urandom;
      bus.s_vld  = 1'b1;
      bus.s_data = d;
      #1;
      n_checks++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL return8 s_ack: got %b want 1", s_ack); end
      bus.din_leaf_bft2endpoint = pkt(2, 0, 0, 32'd92);
      tick();
      bus.din_leaf_bft2endpoint = '0;
      bus.s_vld = 1'b0;
      n_checks++; if (dout !== pkt(2, 2, exp_seq, d)) begin n_fail++; $display("FAIL net pkt: got %h want %h", dout, pkt(2, 2, exp_seq, d)); end
      n_checks++; if (credits !== 8'd99) begin n_fail++; $display("FAIL net credits: got %0d want 99", credits); end
      exp_seq++;
      bus.din_leaf_bft2endpoint = pkt(2, 0, 0, 32'd1);
      tick();
      n_checks++; if (credits !== 8'd100) begin n_fail++; $display("FAIL return1 credits: got %0d want 100", credits); end
      bus.din_leaf_bft2endpoint = pkt(2, 0, 0, 32'd200);
      tick();
      bus.din_leaf_bft2endpoint = '0;
      n_checks++; if (credits !== 8'd128) begin n_fail++; $display("FAIL saturate credits: got %0d want 128", credits); end
      n_checks++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL control_not_stored m_vld: got %b want 0", m_vld); end
      exp_credits = 128;
   endtask

   task automatic test_resend;
      logic [31:0] w5;
      logic [31:0] nxt;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         w5 = $urandom;
         bus.s_vld  = 1'b1;
         bus.s_data = w5;
         tick();
         n_checks++; if (dout !== pkt(2, 2, i, w5)) begin n_fail++; $display("FAIL resend pre pkt%0d: got %h want %h", i, dout, pkt(2, 2, i, w5)); end
      end
      nxt = $urandom;
      bus.s_data = nxt;
      bus.resend = 1'b1;
      #1;
      n_checks++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL resend s_ack: got %b want 0", s_ack); end
      tick();
      n_checks++; if (dout !== pkt(2, 2, 5, w5)) begin n_fail++; $display("FAIL hold pkt: got %h want %h", dout, pkt(2, 2, 5, w5)); end
      bus.resend = 1'b0;
      #1;
      n_checks++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL hold s_ack: got %b want 0", s_ack); end
      tick();
      n_checks++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL post_hold s_ack: got %b want 1", s_ack); end
      n_checks++; if (credits !== 8'd122) begin n_fail++; $display("FAIL hold credits: got %0d want 122", credits); end
      tick();
      bus.s_vld = 1'b0;
      n_checks++; if (dout !== pkt(2, 2, 6, nxt)) begin n_fail++; $display("FAIL post_hold pkt: got %h want %h", dout, pkt(2, 2, 6, nxt)); end
      n_checks++; if (credits !== 8'd121) begin n_fail++; $display("FAIL post_hold credits: got %0d want 121", credits); end
      exp_seq = 7;
      exp_credits = 121;
      tick();
   endtask

   task automatic test_rx_overflow;
      logic [31:0] q[$];
      logic [31:0] p;
      int ctrl_seen;
      do_reset();
      n_checks++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL rx empty m_vld: got %b want 0", m_vld); end
      for (int i = 0; i < 17; i++) begin
         p = $urandom;
         bus.din_leaf_bft2endpoint = pkt(int'($urandom_range(0, 31)), int'($urandom_range(1, 15)), i, p);
         if (q.size() < 16) q.push_back(p);
         tick();
         n_checks++; if (resend_out !== (i == 16)) begin n_fail++; $display("FAIL overflow resend_out%0d: got %b want %b", i, resend_out, (i == 16)); end
         n_checks++; if (m_vld !== 1'b1) begin n_fail++; $display("FAIL overflow m_vld%0d: got %b want 1", i, m_vld); end
      end
      p = $urandom;
      bus.din_leaf_bft2endpoint = pkt(7, 9, 0, p);
      bus.m_ack = 1'b1;
      n_checks++; if (m_data !== q[0]) begin n_fail++; $display("FAIL full_pushpop m_data: got %h want %h", m_data, q[0]); end
      tick();
      void'(q.pop_front());
      q.push_back(p);
      bus.din_leaf_bft2endpoint = '0;
      n_checks++; if (resend_out !== 1'b0) begin n_fail++; $display("FAIL resend_out_one_cycle: got %b want 0", resend_out); end
      ctrl_seen = 0;
      for (int i = 0; i < 16 && q.size() > 0; i++) begin
         n_checks++; if (m_vld !== 1'b1 || m_data !== q[0]) begin n_fail++; $display("FAIL drain_rx word%0d: got vld=%b %h want vld=1 %h", i, m_vld, m_data, q[0]); end
         tick();
         void'(q.pop_front());
         if (dout[48]) begin
            ctrl_seen++;
            n_checks++; if (dout !== ctrl_pkt(0, 8)) begin n_fail++; $display("FAIL rx update pkt: got %h want %h", dout, ctrl_pkt(0, 8)); end
         end
      end
      bus.m_ack = 1'b0;
      n_checks++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL drained m_vld: got %b want 0", m_vld); end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (dout[48]) ctrl_seen++;
      end
      n_checks++; if (ctrl_seen !== 2) begin n_fail++; $display("FAIL rx update count: got %0d want 2", ctrl_seen); end
   endtask

   task automatic test_update;
      logic [31:0] q[$];
      logic [31:0] d;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         bus.din_leaf_bft2endpoint = pkt(1, 3, i, d);
         q.push_back(d);
         tick();
      end
      bus.din_leaf_bft2endpoint = '0;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         bus.m_ack  = 1'b1;
         bus.s_vld  = 1'b1;
         bus.s_data = d;
         #1;
         n_checks++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL update s_ack%0d: got %b want 1", i, s_ack); end
         n_checks++; if (m_data !== q[0]) begin n_fail++; $display("FAIL update m_data%0d: got %h want %h", i, m_data, q[0]); end
         tick();
         void'(q.pop_front());
         n_checks++; if (dout !== pkt(2, 2, exp_seq, d)) begin n_fail++; $display("FAIL update data pkt%0d: got %h want %h", i, dout, pkt(2, 2, exp_seq, d)); end
         exp_seq++;
         exp_credits--;
      end
      d = $urandom;
      bus.m_ack  = 1'b0;
      bus.s_data = d;
      #1;
      n_checks++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL update pending s_ack: got %b want 0", s_ack); end
      tick();
      n_checks++; if (dout !== ctrl_pkt(exp_seq, 8)) begin n_fail++; $display("FAIL update ctrl pkt: got %h want %h", dout, ctrl_pkt(exp_seq, 8)); end
      n_checks++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL after update s_ack: got %b want 1", s_ack); end
      tick();
      bus.s_vld = 1'b0;
      n_checks++; if (dout !== pkt(2, 2, exp_seq, d)) begin n_fail++; $display("FAIL after update pkt: got %h want %h", dout, pkt(2, 2, exp_seq, d)); end
      exp_seq++;
      exp_credits--;
      n_checks++; if (credits !== 8'(exp_credits)) begin n_fail++; $display("FAIL update credits: got %0d want %0d", credits, exp_credits); end
      tick();
   endtask

   task automatic test_reset_mid_hold;
      logic [31:0] d;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         bus.din_leaf_bft2endpoint = pkt(1, 4, i, $urandom);
         tick();
      end
      bus.din_leaf_bft2endpoint = '0;
      d = $urandom;
      bus.s_vld  = 1'b1;
      bus.s_data = d;
      tick();
      bus.s_vld  = 1'b0;
      bus.resend = 1'b1;
      tick();
      n_checks++; if (dout !== pkt(2, 2, 0, d)) begin n_fail++; $display("FAIL mid_hold pkt: got %h want %h", dout, pkt(2, 2, 0, d)); end
      reset = 1'b1;
      tick();
      n_checks++; if (dout !== 49'd0) begin n_fail++; $display("FAIL mid_hold reset dout: got %h want 0", dout); end
      n_checks++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL mid_hold reset s_ack: got %b want 0", s_ack); end
      n_checks++; if (m_vld !== 1'b0 || m_data !== 32'd0) begin n_fail++; $display("FAIL mid_hold reset rx: got vld=%b %h want vld=0 0", m_vld, m_data); end
      n_checks++; if (resend_out !== 1'b0) begin n_fail++; $display("FAIL mid_hold reset resend_out: got %b want 0", resend_out); end
      n_checks++; if (credits !== 8'd128) begin n_fail++; $display("FAIL mid_hold reset credits: got %0d want 128", credits); end
      reset = 1'b0;
      bus.resend = 1'b0;
      d = $urandom;
      bus.s_vld  = 1'b1;
      bus.s_data = d;
      tick();
      bus.s_vld = 1'b0;
      n_checks++; if (dout !== pkt(2, 2, 0, d)) begin n_fail++; $display("FAIL mid_hold restart pkt: got %h want %h", dout, pkt(2, 2, 0, d)); end
      tick();
   endtask

   task automatic test_random_rx;
      logic [31:0] q[$];
      logic [31:0] p;
      bit push;
      bit pop_req;
      bit pop;
      bit full;
      bit exp_ro;
      int pops;
      int ctrl_seen;
      do_reset();
      pops = 0;
      ctrl_seen = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         push    = (cyc < 150) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
         pop_req = $urandom_range(0, 1) == 1;
         p = $urandom;
         n_checks++; if (m_vld !== (q.size() != 0)) begin n_fail++; $display("FAIL random m_vld c%0d: got %b want %b", cyc, m_vld, (q.size() != 0)); end
         if (q.size() != 0) begin
            n_checks++; if (m_data !== q[0]) begin n_fail++; $display("FAIL random m_data c%0d: got %h want %h", cyc, m_data, q[0]); end
         end
         bus.din_leaf_bft2endpoint = push ? pkt(int'($urandom_range(0, 31)), int'($urandom_range(1, 15)), cyc, p) : 49'd0;
         bus.m_ack = pop_req;
         tick();
         full = (q.size() == 16);
         pop  = pop_req && (q.size() != 0);
         if (pop) begin
            void'(q.pop_front());
            pops++;
         end
         exp_ro = push && full && !pop;
         if (push && !exp_ro) q.push_back(p);
         n_checks++; if (resend_out !== exp_ro) begin n_fail++; $display("FAIL random resend_out c%0d: got %b want %b", cyc, resend_out, exp_ro); end
         if (dout[48]) begin
            ctrl_seen++;
            n_checks++; if (dout !== ctrl_pkt(0, 8)) begin n_fail++; $display("FAIL random update pkt c%0d: got %h want %h", cyc, dout, ctrl_pkt(0, 8)); end
         end
      end
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         tick();
         if (dout[48]) ctrl_seen++;
      end
      n_checks++; if (ctrl_seen !== pops / 8) begin n_fail++; $display("FAIL random update count: got %0d want %0d", ctrl_seen, pops / 8); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_tx_basic();
      test_credit_return();
      test_resend();
      test_rx_overflow();
      test_update();
      test_reset_mid_hold();
      test_random_rx();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bft_leaf_endpoint.md
Name: bft_leaf_endpoint

Overview:
- BFT-side peer of a leaf interface. Used as a host/DMA-side endpoint, or as a testbench stand-in for a leaf.
- TX: packs a user word stream (ap_vld/ap_ack) into 49-bit BFT packets addressed to one destination leaf/port. Sending is gated by credits that the destination returns in freespace-update packets.
- RX: decodes inbound BFT packets into a buffered output stream and returns its own freespace updates.

Parameters:
- PACKET_BITS, 49, packet width. Layout: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
- PAYLOAD_BITS, 32, payload width.
- NUM_LEAF_BITS, 5, leaf field width.
- NUM_PORT_BITS, 4, port field width.
- NUM_ADDR_BITS, 7, addr/sequence field width.
- DST_LEAF, 2, destination leaf for all TX packets.
- DST_PORT, 2, destination port for data packets. Must be nonzero; port 0 is the control port.
- SELF_LEAF, 1, own leaf number, placed in control packet payload[31:27].
- CREDIT_INIT, 128, initial and maximum TX credits.
- RX_DEPTH, 16, RX FIFO depth (power of 2).
- FREESPACE_UPDATE_SIZE, 8, RX words popped per returned update. Must be ≤ RX_DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- din_leaf_bft2endpoint  in  49  packet from BFT.
- dout_leaf_endpoint2bft  out  49  packet to BFT.
- resend  in  1  BFT rejected the packet driven in the previous cycle.
- resend_out  out  1  endpoint dropped the packet received in the previous cycle.
- s_data  in  32  TX user word.
- s_vld  in  1  TX word valid.
- s_ack  out  1  TX accept. A word transfers in any cycle where s_vld & s_ack.
- m_data  out  32  RX head word.
- m_vld  out  1  RX FIFO non-empty.
- m_ack  in  1  pop. A word transfers in any cycle where m_vld & m_ack.
- credits  out  8  current TX credit count (debug).

Behaviour:
- Reset values: dout_leaf_endpoint2bft=0, resend_out=0, s_ack=0, m_vld=0, m_data=0, credits=CREDIT_INIT. Also cleared: tx_seq=0, pop_cnt=0, RX FIFO empty, TX FSM in SEND. Reset mid-packet discards all in-flight state and returns to these values.
- TX FSM, state SEND:
  - s_ack = credits>0 & !resend & !upd_pending (combinational).
  - A pending update takes priority over data. It drives a control packet {1, DST_LEAF, 0, tx_seq, SELF_LEAF, pop_cnt snapshot}.
  - Otherwise, on a transfer, dout <= {1, DST_LEAF, DST_PORT, tx_seq, s_data}; tx_seq+1 (mod 128); credits-1.
  - If neither, dout <= 0.
  - Output is registered: the packet appears one cycle after the transfer.
- TX FSM, state HOLD:
  - If resend=1 in the cycle after a valid packet was driven, enter HOLD.
  - In HOLD, dout re-presents the same registered packet unchanged and s_ack=0.
  - Return to SEND when resend=0 in the cycle after re-presenting.
  - Credits and tx_seq are not re-charged on resend.
  - resend while dout valid bit is 0 is ignored.
- Credit return: inbound packet with valid=1 and port==0 gives credits += payload[7:0], saturating at CREDIT_INIT.
  - If a credit return and a send happen in the same cycle, the net change is applied (+n−1), then saturated.
- RX data: inbound valid=1 with port≠0 pushes payload into the FIFO.
  - FIFO full with no simultaneous pop: packet dropped and resend_out=1 on the next cycle, for one cycle.
  - Push and pop in the same cycle while full: push accepted.
  - Packets with leaf≠SELF_LEAF are still accepted (routing is the BFT's job).
- RX output: m_data/m_vld driven from the FIFO head, first-word-fall-through. Push-to-m_vld latency is 1 cycle.
- Freespace update generation:
  - Each pop increments pop_cnt.
  - When pop_cnt reaches FREESPACE_UPDATE_SIZE: set upd_pending, snapshot the count, subtract it from pop_cnt. Pops in that cycle are still counted.
  - upd_pending clears when the control packet is driven.
  - A second threshold crossing while one update is pending accumulates into the snapshot.

Test Plan:
- After reset, s_vld=1 with words 0xA0..0xA4 -> five packets, one per cycle, each 1 cycle after its transfer: leaf=2, port=2, addr 0..4, payloads match; credits 128→123.
- Send 128 words with no credit return -> s_ack=0 once credits=0. Inject control packet, payload=8 -> credits=8, s_ack=1 next cycle. Payload=200 at credits=100 -> credits=128.
- Assert resend one cycle after packet addr=5 -> identical packet (addr 5, same payload) re-driven, s_ack=0 in HOLD. Next data packet has addr=6; credits decremented only once.
- Inject 17 data packets with m_ack=0 -> 16 stored, 17th dropped, resend_out pulses once. Pop all -> payload order preserved, m_vld=0 after the 16th pop.
- Pop 8 words while s_vld=1 -> control packet (port 0, payload[7:0]=8, payload[31:27]=1) emitted before the next data packet, s_ack=0 that cycle.
- Assert reset mid-HOLD with a non-empty FIFO -> next cycle all outputs at reset values, credits=128, addr restarts at 0.
